// File: rtl/host_cmd_gen_pkg.sv
// host_cmd_gen_pkg
//   Shared definitions for the host-side command initiator: protocol opcode
//   bytes, REQ_CMD encodings, FSM state encoding and per-command TX/RX byte
//   counts, with small helpers that map a command to its frame shape.
package host_cmd_gen_pkg;

    localparam logic [7:0] RF_WR_CMD   = 8'hAA;
    localparam logic [7:0] RF_RD_CMD   = 8'hBB;
    localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

    typedef enum logic [1:0] {
        REQ_RF_WR   = 2'd0,
        REQ_RF_RD   = 2'd1,
        REQ_ALU_OP  = 2'd2,
        REQ_ALU_NOP = 2'd3
    } req_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RX_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int unsigned TX_BYTES_RF_WR   = 3;
    localparam int unsigned TX_BYTES_RF_RD   = 2;
    localparam int unsigned TX_BYTES_ALU_OP  = 4;
    localparam int unsigned TX_BYTES_ALU_NOP = 2;

    localparam int unsigned RX_BYTES_RF_WR   = 0;
    localparam int unsigned RX_BYTES_RF_RD   = 1;
    localparam int unsigned RX_BYTES_ALU     = 2;

    function automatic logic [7:0] cmd_opcode(input req_cmd_e cmd);
        case (cmd)
            REQ_RF_WR:  return RF_WR_CMD;
            REQ_RF_RD:  return RF_RD_CMD;
            REQ_ALU_OP: return ALU_OP_CMD;
            default:    return ALU_NOP_CMD;
        endcase
    endfunction

    // Index of the final byte of the frame for this command.
    function automatic logic [1:0] tx_last_idx(input req_cmd_e cmd);
        case (cmd)
            REQ_RF_WR:  return 2'(TX_BYTES_RF_WR - 1);
            REQ_RF_RD:  return 2'(TX_BYTES_RF_RD - 1);
            REQ_ALU_OP: return 2'(TX_BYTES_ALU_OP - 1);
            default:    return 2'(TX_BYTES_ALU_NOP - 1);
        endcase
    endfunction

    function automatic logic [1:0] rx_bytes(input req_cmd_e cmd);
        case (cmd)
            REQ_RF_WR: return 2'(RX_BYTES_RF_WR);
            REQ_RF_RD: return 2'(RX_BYTES_RF_RD);
            default:   return 2'(RX_BYTES_ALU);
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_gen_if.sv
// host_cmd_gen_if
//   Request, UART TX/RX byte stream and response signals of host_cmd_gen.
//   modport slave : the command generator itself
//   modport master: the environment (request source, UART TX/RX, response sink)
interface host_cmd_gen_if #(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16
);
    logic                     REQ_VALID;
    logic                     REQ_READY;
    logic [1:0]               REQ_CMD;
    logic [ADDR_WIDTH-1:0]    REQ_ADDR;
    logic [WIDTH-1:0]         REQ_DATA;
    logic [WIDTH-1:0]         REQ_OPB;
    logic [3:0]               REQ_FUN;
    logic [WIDTH-1:0]         TX_P_DATA;
    logic                     TX_D_VALID;
    logic                     BUSY;
    logic [WIDTH-1:0]         RX_P_DATA;
    logic                     RX_D_VALID;
    logic [ALU_OUT_WIDTH-1:0] RSP_DATA;
    logic                     RSP_VALID;
    logic                     RSP_ERR;

    modport slave (
        input  REQ_VALID, REQ_CMD, REQ_ADDR, REQ_DATA, REQ_OPB, REQ_FUN,
        input  BUSY, RX_P_DATA, RX_D_VALID,
        output REQ_READY, TX_P_DATA, TX_D_VALID, RSP_DATA, RSP_VALID, RSP_ERR
    );

    modport master (
        output REQ_VALID, REQ_CMD, REQ_ADDR, REQ_DATA, REQ_OPB, REQ_FUN,
        output BUSY, RX_P_DATA, RX_D_VALID,
        input  REQ_READY, TX_P_DATA, TX_D_VALID, RSP_DATA, RSP_VALID, RSP_ERR
    );
endinterface

// File: rtl/host_cmd_gen_rsp_timer.sv
// rsp_timer
//   Response timeout counter. Cleared while clr is high, counts while en is
//   high, expire is high while enabled and the count sits at TIMEOUT_CYCLES-1.
//   Ports: clk, rst_n (async active-low), clr, en, expire.
module rsp_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = en && (cnt_q == LAST);
endmodule

// File: rtl/host_cmd_gen.sv
// host_cmd_gen
//   Host-side command initiator: takes one request over REQ_VALID/REQ_READY,
//   serialises it as a protocol frame on the UART-TX byte stream, collects the
//   response bytes from the UART-RX stream and reports them with a one-cycle
//   RSP_VALID pulse.
//   Ports: CLK, RST (async active-low), bus (host_cmd_gen_if.slave).
//   Optional: define RSP_TIMEOUT_EN to bound the response wait to
//   TIMEOUT_CYCLES cycles (RSP_ERR=1 on expiry); otherwise RSP_ERR is 0.
module host_cmd_gen
    import host_cmd_gen_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          ADDR_WIDTH     = 4,
    parameter int          ALU_OUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic           CLK,
    input logic           RST,
    host_cmd_gen_if.slave bus
);
    state_e                   state_q, state_d;
    req_cmd_e                 cmd_q;
    logic [1:0]               idx_q;
    logic                     rx_cnt_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [WIDTH-1:0]         data_q;
    logic [WIDTH-1:0]         opb_q;
    logic [3:0]               fun_q;
    logic [ALU_OUT_WIDTH-1:0] rsp_q;
    logic [WIDTH-1:0]         tx_byte;

    logic accept, tx_fire, rx_fire, rx_last, tmo, tmr_expire;

`ifdef RSP_TIMEOUT_EN
    logic err_q;

    rsp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rsp_timer (
        .clk    (CLK),
        .rst_n  (RST),
        .clr    (state_q != ST_RX_WAIT),
        .en     (state_q == ST_RX_WAIT),
        .expire (tmr_expire)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (tmo) begin
            err_q <= 1'b1;
        end
    end

    assign bus.RSP_ERR = (state_q == ST_DONE) && err_q;
`else
    assign tmr_expire  = 1'b0;
    assign bus.RSP_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        tx_fire = 1'b0;
        rx_fire = 1'b0;
        rx_last = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_VALID) begin
                    accept  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!bus.BUSY) begin
                    tx_fire = 1'b1;
                    if (idx_q == tx_last_idx(cmd_q)) begin
                        state_d = (cmd_q == REQ_RF_WR) ? ST_DONE : ST_RX_WAIT;
                    end
                end
            end
            ST_RX_WAIT: begin
                if (bus.RX_D_VALID) begin
                    rx_fire = 1'b1;
                    rx_last = (({1'b0, rx_cnt_q} + 2'd1) == rx_bytes(cmd_q));
                end
                // A byte completing the response wins over a same-cycle expiry.
                if (rx_last) begin
                    state_d = ST_DONE;
                end else if (tmr_expire) begin
                    tmo     = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cmd_q    <= REQ_RF_WR;
            idx_q    <= '0;
            rx_cnt_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            opb_q    <= '0;
            fun_q    <= '0;
            rsp_q    <= '0;
        end else begin
            if (accept) begin
                cmd_q    <= req_cmd_e'(bus.REQ_CMD);
                addr_q   <= bus.REQ_ADDR;
                data_q   <= bus.REQ_DATA;
                opb_q    <= bus.REQ_OPB;
                fun_q    <= bus.REQ_FUN;
                idx_q    <= '0;
                rx_cnt_q <= 1'b0;
                rsp_q    <= '0;
            end
            if (tx_fire) begin
                idx_q <= idx_q + 2'd1;
            end
            if (rx_fire) begin
                rx_cnt_q <= 1'b1;
                // First byte lands low with the upper byte cleared; second byte is the high byte.
                if (rx_cnt_q) begin
                    rsp_q[ALU_OUT_WIDTH-1:WIDTH] <= bus.RX_P_DATA;
                end else begin
                    rsp_q <= ALU_OUT_WIDTH'(bus.RX_P_DATA);
                end
            end
            if (tmo) begin
                rsp_q <= '0;
            end
        end
    end

    always_comb begin
        tx_byte = '0;
        case (idx_q)
            2'd0: tx_byte = WIDTH'(cmd_opcode(cmd_q));
            2'd1: begin
                case (cmd_q)
                    REQ_RF_WR, REQ_RF_RD: tx_byte = WIDTH'(addr_q);
                    REQ_ALU_OP:           tx_byte = data_q;
                    default:              tx_byte = WIDTH'(fun_q);
                endcase
            end
            2'd2: tx_byte = (cmd_q == REQ_RF_WR) ? data_q : opb_q;
            default: tx_byte = WIDTH'(fun_q);
        endcase
    end

    assign bus.REQ_READY  = (state_q == ST_IDLE);
    assign bus.TX_D_VALID = (state_q == ST_SEND);
    assign bus.TX_P_DATA  = (state_q == ST_SEND) ? tx_byte : '0;
    assign bus.RSP_VALID  = (state_q == ST_DONE);
    assign bus.RSP_DATA   = (state_q == ST_DONE) ? rsp_q : '0;

endmodule

// File: tb/tb_host_cmd_gen.sv
// tb_host_cmd_gen
//   Directed bench for host_cmd_gen. A UART model owns BUSY and records every
//   accepted TX byte and response; the main sequence pushes expected frames and
//   responses into queues and compares them as the DUT produces them.
module tb_host_cmd_gen;
    localparam int TMO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    host_cmd_gen_if bus ();

    host_cmd_gen #(
        .WIDTH          (8),
        .ADDR_WIDTH     (4),
        .ALU_OUT_WIDTH  (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  obs_tx[$];
    logic [16:0] exp_rsp[$];
    logic [16:0] obs_rsp[$];
    int          hold_q[$];

    int cyc = 0;
    int last_xfer_cyc = 0, rsp_cyc = 0, rx_cyc = 0, acc_cyc = 0, first_cyc = 0;
    int busy_left = 0;
    bit busy_pend = 0, stall_prev = 0, prev_valid = 0;
    logic [7:0] stall_data = '0;

    // UART TX model and output monitor, evaluated mid-cycle.
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            busy_pend  = 0;
            busy_left  = 0;
            stall_prev = 0;
            prev_valid = 0;
            bus.BUSY   = 1'b0;
        end else begin
            if (busy_pend) begin
                busy_left = (hold_q.size() > 0) ? hold_q.pop_front() : 1;
                busy_pend = 0;
            end
            bus.BUSY = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (stall_prev) begin
                total++;
                assert (bus.TX_D_VALID === 1'b1 && bus.TX_P_DATA === stall_data) passed++;
                else $error("FAIL tx_hold: got valid=%b data=%h expected valid=1 data=%h",
                            bus.TX_D_VALID, bus.TX_P_DATA, stall_data);
            end
            stall_prev = bus.TX_D_VALID && bus.BUSY;
            stall_data = bus.TX_P_DATA;
            if (bus.REQ_VALID && bus.REQ_READY) acc_cyc = cyc;
            if (bus.TX_D_VALID && !prev_valid) first_cyc = cyc;
            prev_valid = bus.TX_D_VALID;
            if (bus.TX_D_VALID && !bus.BUSY) begin
                obs_tx.push_back(bus.TX_P_DATA);
                last_xfer_cyc = cyc;
                busy_pend = 1;
            end
            if (bus.RX_D_VALID) rx_cyc = cyc;
            if (bus.RSP_VALID) begin
                obs_rsp.push_back({bus.RSP_ERR, bus.RSP_DATA});
                rsp_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_req(input logic [1:0] cmd, input logic [3:0] addr,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        int n;
        case (cmd)
            2'd0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(a); end
            2'd1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); end
            2'd2: begin
                exp_tx.push_back(8'hCC); exp_tx.push_back(a);
                exp_tx.push_back(b);     exp_tx.push_back({4'h0, fun});
            end
            default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fun}); end
        endcase
        n = 0;
        sample();
        while (!bus.REQ_READY && n < 100) begin
            sample();
            n++;
        end
        chk("req_ready_before_send", 32'(bus.REQ_READY), 32'd1);
        drive_step();
        bus.REQ_CMD   = cmd;
        bus.REQ_ADDR  = addr;
        bus.REQ_DATA  = a;
        bus.REQ_OPB   = b;
        bus.REQ_FUN   = fun;
        bus.REQ_VALID = 1'b1;
        drive_step();
        bus.REQ_VALID = 1'b0;
        bus.REQ_CMD   = 2'($urandom);
        bus.REQ_ADDR  = 4'($urandom);
        bus.REQ_DATA  = 8'($urandom);
        bus.REQ_OPB   = 8'($urandom);
        bus.REQ_FUN   = 4'($urandom);
    endtask

    task automatic wait_tx(input string tag, input int count);
        int n = 0;
        while (obs_tx.size() < count && n < 200) begin
            sample();
            n++;
        end
        chk({tag, "_tx_reached"}, 32'(obs_tx.size() >= count), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (obs_rsp.size() == 0 && n < 400) begin
            sample();
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(obs_rsp.size() > 0), 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        bus.RX_P_DATA  = d;
        bus.RX_D_VALID = 1'b1;
        drive_step();
        bus.RX_D_VALID = 1'b0;
        bus.RX_P_DATA  = 8'($urandom);
    endtask

    task automatic check_txn(input string tag);
        chk({tag, "_tx_count"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
        while (exp_tx.size() > 0 && obs_tx.size() > 0)
            chk({tag, "_tx_byte"}, 32'(obs_tx.pop_front()), 32'(exp_tx.pop_front()));
        if (exp_rsp.size() > 0 && obs_rsp.size() > 0)
            chk({tag, "_rsp"}, 32'(obs_rsp.pop_front()), 32'(exp_rsp.pop_front()));
        exp_tx.delete();
        obs_tx.delete();
        exp_rsp.delete();
        obs_rsp.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(bus.REQ_READY),  32'd1);
        chk({tag, "_tx_valid"},   32'(bus.TX_D_VALID), 32'd0);
        chk({tag, "_tx_data"},    32'(bus.TX_P_DATA),  32'd0);
        chk({tag, "_rsp_valid"},  32'(bus.RSP_VALID),  32'd0);
        chk({tag, "_rsp_data"},   32'(bus.RSP_DATA),   32'd0);
        chk({tag, "_rsp_err"},    32'(bus.RSP_ERR),    32'd0);
    endtask

    initial begin
        bit ready_seen;
        int n;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_CMD    = '0;
        bus.REQ_ADDR   = '0;
        bus.REQ_DATA   = '0;
        bus.REQ_OPB    = '0;
        bus.REQ_FUN    = '0;
        bus.RX_P_DATA  = '0;
        bus.RX_D_VALID = 1'b0;

        // Reset values
        RST = 1'b0;
        repeat (3) sample();
        chk_reset_outputs("reset");
        drive_step();
        RST = 1'b1;
        sample();
        chk("post_reset_ready", 32'(bus.REQ_READY), 32'd1);

        // Write addr 5, data 0x3C, BUSY one cycle after each byte
        hold_q = {1, 1, 1};
        send_req(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
        exp_rsp.push_back(17'h0_0000);
        wait_rsp("wr");
        chk("wr_rsp_after_last_tx", 32'(rsp_cyc), 32'(last_xfer_cyc + 1));
        chk("wr_first_tx_latency", 32'(first_cyc), 32'(acc_cyc + 1));
        check_txn("wr");
        sample();
        chk("wr_ready_after_done", 32'(bus.REQ_READY), 32'd1);

        // Read addr 2, response 20 cycles after last TX byte
        hold_q = {1, 1};
        send_req(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
        wait_tx("rd", 2);
        repeat (20) drive_step();
        rx_byte(8'h7E);
        exp_rsp.push_back(17'h0_007E);
        wait_rsp("rd");
        chk("rd_rsp_latency", 32'(rsp_cyc), 32'(rx_cyc + 1));
        chk("rd_ready_low_in_done", 32'(bus.REQ_READY), 32'd0);
        sample();
        chk("rd_ready_after_done", 32'(bus.REQ_READY), 32'd1);
        check_txn("rd");

        // ALU with operands; stray RX strobe during SEND must be ignored
        hold_q = {2, 2, 2, 2};
        send_req(2'd2, 4'h0, 8'h10, 8'h20, 4'h0);
        rx_byte(8'hEE);
        wait_tx("alu", 4);
        drive_step();
        rx_byte(8'h30);
        rx_byte(8'h00);
        exp_rsp.push_back(17'h0_0030);
        wait_rsp("alu");
        chk("alu_rsp_latency", 32'(rsp_cyc), 32'(rx_cyc + 1));
        check_txn("alu");

        // ALU without operands, gap between response bytes, low byte first
        hold_q = {1, 1};
        send_req(2'd3, 4'h0, 8'h00, 8'h00, 4'h9);
        wait_tx("nop", 2);
        drive_step();
        rx_byte(8'h34);
        repeat (3) drive_step();
        rx_byte(8'h12);
        exp_rsp.push_back(17'h0_1234);
        wait_rsp("nop");
        check_txn("nop");

        // Long BUSY stall on the second byte
        hold_q = {10, 1, 1};
        send_req(2'd0, 4'hA, 8'h5A, 8'h00, 4'h0);
        exp_rsp.push_back(17'h0_0000);
        ready_seen = 0;
        n = 0;
        while (obs_rsp.size() == 0 && n < 200) begin
            if (bus.REQ_READY) ready_seen = 1;
            sample();
            n++;
        end
        chk("stall_ready_low", 32'(ready_seen), 32'd0);
        chk("stall_rsp_seen", 32'(obs_rsp.size() > 0), 32'd1);
        chk("stall_duration", 32'(rsp_cyc), 32'(first_cyc + 14));
        check_txn("stall");

`ifdef RSP_TIMEOUT_EN
        // Read with no response: timeout after TMO cycles in RX_WAIT
        hold_q = {1, 1};
        send_req(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
        exp_rsp.push_back(17'h1_0000);
        wait_rsp("tmo");
        chk("tmo_latency", 32'(rsp_cyc), 32'(last_xfer_cyc + 1 + TMO));
        check_txn("tmo");
        hold_q = {1, 1, 1};
        send_req(2'd0, 4'h1, 8'hC3, 8'h00, 4'h0);
        exp_rsp.push_back(17'h0_0000);
        wait_rsp("after_tmo");
        check_txn("after_tmo");
`endif

        // Reset during the third byte of an ALU frame
        hold_q = {1, 1, 1, 1};
        send_req(2'd2, 4'h0, 8'h11, 8'h22, 4'h3);
        wait_tx("rst", 2);
        drive_step();
        RST = 1'b0;
        sample();
        chk_reset_outputs("midframe_reset");
        drive_step();
        RST = 1'b1;
        hold_q.delete();
        exp_tx.delete();
        obs_tx.delete();
        exp_rsp.delete();
        repeat (4) sample();
        chk("midframe_no_rsp", 32'(obs_rsp.size()), 32'd0);
        chk("midframe_ready", 32'(bus.REQ_READY), 32'd1);

        // Normal read afterwards
        hold_q = {1, 1};
        send_req(2'd1, 4'hF, 8'h00, 8'h00, 4'h0);
        wait_tx("rd2", 2);
        drive_step();
        rx_byte(8'hA5);
        exp_rsp.push_back(17'h0_00A5);
        wait_rsp("rd2");
        check_txn("rd2");

        repeat (3) sample();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
